nibble_serial_adder: RTL

- Sequencer that adds two WIDTH-bit operands by driving the team's existing 4-bit ripple adder (ports a, b, cin, sum, cout) one nibble per clock, least-significant nibble first.
- Sits directly upstream of the 4-bit adder, feeding its a/b/cin, and directly downstream of it, consuming its sum/cout.
- Provides valid/ready handshakes on both the operand side and the result side.
- The 4-bit adder remains a separate combinational instance at the parent level. This block only drives and samples it.

---
 rtl/nibble_serial_adder_pkg.sv | 12 +
 rtl/ripple_adder4.sv | 26 ++
 rtl/nibble_serial_adder.sv | 115 +++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and sequencer state encoding for the nibble-serial adder.
package nibble_serial_adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/ripple_adder4.sv
// Existing 4-bit combinational ripple adder, instantiated beside the sequencer.
module ripple_adder4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] carry;

   assign carry[0] = cin;

   // One full adder per bit, carry rippling upward.
   always_comb begin
      sum        = '0;
      carry[4:1] = '0;
      for (int i = 0; i < 4; i++) begin
         sum[i]     = a[i] ^ b[i] ^ carry[i];
         carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
      end
   end

   assign cout = carry[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Sequencer that adds two WIDTH-bit operands one nibble per clock by driving an
// external 4-bit adder, least-significant nibble first.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. in_ready is high only in IDLE; out_valid is high only in DONE and stays
// high, with result/result_cout stable, until out_ready is seen at an edge.
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16  // multiple of 4, at least 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_cin,
   output logic [3:0]       add_a,
   output logic [3:0]       add_b,
   output logic             add_cin,
   input  logic [3:0]       add_sum,
   input  logic             add_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             result_cout,
   output logic [1:0]       dbg_state_o
);

   localparam int NIB   = WIDTH / NIBBLE_W;
   localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

   state_t           state_q, state_d;
   // Operands shift right one nibble per RUN cycle, so nibble idx is always at [3:0].
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             rcout_q, rcout_d;

   // Next-state and datapath updates for the IDLE -> RUN -> DONE sequence.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      carry_d  = carry_q;
      idx_d    = idx_q;
      result_d = result_q;
      rcout_d  = rcout_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = op_a;
               b_d     = op_b;
               carry_d = op_cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> NIBBLE_W;
            b_d     = b_q >> NIBBLE_W;
            carry_d = add_cout;
            idx_d   = idx_q + IDX_W'(1);
            result_d[idx_q*NIBBLE_W +: NIBBLE_W] = add_sum;
            if (idx_q == LAST_IDX) begin
               idx_d   = '0;
               rcout_d = add_cout;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         result_q <= '0;
         rcout_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         carry_q  <= carry_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         rcout_q  <= rcout_d;
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = (state_q == DONE);
   // Adder inputs are forced to zero whenever no nibble is being processed.
   assign add_a       = (state_q == RUN) ? a_q[NIBBLE_W-1:0] : '0;
   assign add_b       = (state_q == RUN) ? b_q[NIBBLE_W-1:0] : '0;
   assign add_cin     = (state_q == RUN) ? carry_q : 1'b0;
   assign result      = result_q;
   assign result_cout = rcout_q;
   assign dbg_state_o = state_q;

endmodule
